// File: rtl/npc_bpu_if.sv
// rtl/npc_bpu_if.sv - fetch-side and EX-resolution signals of the next-PC predictor
interface npc_bpu_if;
  logic [31:0] PC;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] NPC;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  // master is the pipeline side, slave is the predictor
  modport master (
    output PC, stall, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  NPC, pred_taken, pred_target, flush
  );

  modport slave (
    input  PC, stall, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output NPC, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/npc_bpu.sv
// rtl/npc_bpu.sv - next-PC generator with direct-mapped BTB and 2-bit counters
module npc_bpu #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic     clk,
  input  logic     rst,
  npc_bpu_if.slave bus
);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tag     [ENTRIES];
  logic [31:0]      target  [ENTRIES];
  logic [1:0]       ctr     [ENTRIES];
  logic             is_jump [ENTRIES];

  logic             pend;
  logic [31:0]      pend_addr;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic [31:0]      pc_plus4, ex_plus4, corr;
  logic             f_hit, e_hit, mis, pred_taken_i;
  logic [31:0]      pred_target_i;
  logic [1:0]       ctr_next;

  assign f_idx    = bus.PC[IDX_W+1:2];
  assign f_tag    = bus.PC[31:IDX_W+2];
  assign e_idx    = bus.ex_pc[IDX_W+1:2];
  assign e_tag    = bus.ex_pc[31:IDX_W+2];
  assign pc_plus4 = bus.PC + 32'd4;
  assign ex_plus4 = bus.ex_pc + 32'd4;

  assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);
  assign e_hit = valid[e_idx] && (tag[e_idx] == e_tag);

  assign pred_taken_i  = f_hit && (is_jump[f_idx] || ctr[f_idx][1]);
  assign pred_target_i = f_hit ? target[f_idx] : pc_plus4;

  assign mis  = bus.ex_valid &&
                ((bus.ex_taken != bus.ex_pred_taken) ||
                 (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  assign corr = bus.ex_taken ? bus.ex_target : ex_plus4;

  always_comb begin
    ctr_next = ctr[e_idx];
    if (bus.ex_taken) begin
      if (ctr[e_idx] != 2'b11) ctr_next = ctr[e_idx] + 2'd1;
    end else begin
      if (ctr[e_idx] != 2'b00) ctr_next = ctr[e_idx] - 2'd1;
    end
  end

  // A live EX correction always beats a parked one; the parked one beats prediction
  always_comb begin
    if (mis)
      bus.NPC = corr;
    else if (pend)
      bus.NPC = pend_addr;
    else if (pred_taken_i)
      bus.NPC = pred_target_i;
    else
      bus.NPC = pc_plus4;
  end

  assign bus.pred_taken  = pred_taken_i;
  assign bus.pred_target = pred_target_i;
  assign bus.flush       = mis || pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_addr <= 32'd0;
    end else if (mis && bus.stall) begin
      pend      <= 1'b1;
      pend_addr <= corr;
    end else if (!bus.stall) begin
      pend      <= 1'b0;
    end
  end

  // Training ignores stall: the resolving instruction has already left EX
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        ctr[i]     <= 2'b01;
        is_jump[i] <= 1'b0;
      end
    end else if (bus.ex_valid) begin
      if (e_hit) begin
        if (bus.ex_taken)   target[e_idx] <= bus.ex_target;
        if (!bus.ex_is_jump) ctr[e_idx]   <= ctr_next;
      end else if (bus.ex_taken) begin
        valid[e_idx]   <= 1'b1;
        tag[e_idx]     <= e_tag;
        target[e_idx]  <= bus.ex_target;
        is_jump[e_idx] <= bus.ex_is_jump;
        ctr[e_idx]     <= bus.ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_npc_bpu.sv
// tb/tb_npc_bpu.sv - directed vector table plus randomized model comparison for npc_bpu
module tb_npc_bpu;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  npc_bpu_if bus ();
  npc_bpu #(.ENTRIES(16), .IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          chk;
    logic        r;
    logic [31:0] pc;
    logic        st, exv, exj;
    logic [31:0] expc;
    logic        ext;
    logic [31:0] extg;
    logic        expt;
    logic [31:0] exptg;
    logic [31:0] npc;
    logic        pt, fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit chk, logic r, logic [31:0] pc, logic st, logic exv,
                              logic exj, logic [31:0] expc, logic ext, logic [31:0] extg,
                              logic expt, logic [31:0] exptg, logic [31:0] npc,
                              logic pt, logic fl);
    vec_t v;
    v.chk = chk; v.r = r; v.pc = pc; v.st = st; v.exv = exv; v.exj = exj;
    v.expc = expc; v.ext = ext; v.extg = extg; v.expt = expt; v.exptg = exptg;
    v.npc = npc; v.pt = pt; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: table keyed by word index, counter kept as a clamped integer
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_jmp   [16];
  bit          m_pend;
  logic [31:0] m_paddr;

  function automatic int unsigned idx_of(logic [31:0] a);
    return (a / 4) % 16;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return a / 64;
  endfunction

  function automatic bit m_mis();
    return bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && bus.ex_target != bus.ex_pred_target));
  endfunction

  function automatic logic [31:0] m_corr();
    return bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
  endfunction

  task automatic model_eval(output logic [31:0] npc, output logic pt,
                            output logic [31:0] ptg, output logic fl);
    int unsigned i;
    bit hit;
    i   = idx_of(bus.PC);
    hit = m_valid[i] && m_tag[i] == tag_of(bus.PC);
    pt  = hit && (m_jmp[i] || m_ctr[i] >= 2);
    ptg = hit ? m_tgt[i] : bus.PC + 32'd4;
    fl  = m_mis() || m_pend;
    if (m_mis())     npc = m_corr();
    else if (m_pend) npc = m_paddr;
    else if (pt)     npc = ptg;
    else             npc = bus.PC + 32'd4;
  endtask

  task automatic model_update();
    int unsigned i;
    bit mis;
    if (rst) begin
      m_pend = 0;
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_ctr[k] = 1; m_jmp[k] = 0;
      end
      return;
    end
    mis = m_mis();
    if (mis && bus.stall) begin
      m_pend  = 1;
      m_paddr = m_corr();
    end else if (!bus.stall) begin
      m_pend = 0;
    end
    if (bus.ex_valid) begin
      i = idx_of(bus.ex_pc);
      if (m_valid[i] && m_tag[i] == tag_of(bus.ex_pc)) begin
        if (bus.ex_taken) m_tgt[i] = bus.ex_target;
        if (!bus.ex_is_jump)
          m_ctr[i] = bus.ex_taken ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                                  : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      end else if (bus.ex_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = tag_of(bus.ex_pc);
        m_tgt[i]   = bus.ex_target;
        m_jmp[i]   = bus.ex_is_jump;
        m_ctr[i]   = bus.ex_is_jump ? 3 : 2;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0)
      return 32'hFFFF_FFC0 + 32'(4 * $urandom_range(0, 15));
    return 32'(4 * $urandom_range(0, 47));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e_npc, e_ptg;
    logic        e_pt, e_fl;

    //          chk r  pc            st exv exj expc           ext extg        expt exptg       npc           pt fl
    tbl.push_back(mk(0, 1, 32'h0,       0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h4,        0, 0));
    tbl.push_back(mk(1, 0, 32'hFFFFFFFC,0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'h0,       0, 1, 0, 32'h100,       1, 32'h40,      0, 32'h104,   32'h40,       0, 1));
    tbl.push_back(mk(1, 0, 32'h100,     0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h40,       1, 0));
    tbl.push_back(mk(1, 0, 32'h104,     0, 1, 0, 32'h100,       0, 32'h40,      1, 32'h40,    32'h104,      0, 1));
    tbl.push_back(mk(1, 0, 32'h104,     0, 1, 0, 32'h100,       0, 32'h40,      1, 32'h40,    32'h104,      0, 1));
    tbl.push_back(mk(1, 0, 32'h100,     0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h104,      0, 0));
    tbl.push_back(mk(1, 0, 32'h500,     1, 1, 0, 32'h1F0,       1, 32'h200,     0, 32'h1F4,   32'h200,      0, 1));
    tbl.push_back(mk(1, 0, 32'h500,     1, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h200,      0, 1));
    tbl.push_back(mk(1, 0, 32'h500,     1, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h200,      0, 1));
    tbl.push_back(mk(1, 0, 32'h500,     0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h200,      0, 1));
    tbl.push_back(mk(1, 0, 32'h200,     0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h204,      0, 0));
    tbl.push_back(mk(1, 0, 32'h204,     0, 1, 0, 32'hFFFFFFFC,  0, 32'h0,       1, 32'h40,    32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 32'h200,     0, 1, 1, 32'h80,        1, 32'h300,     0, 32'h84,    32'h300,      0, 1));
    tbl.push_back(mk(1, 0, 32'h80,      0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h300,      1, 0));
    tbl.push_back(mk(1, 0, 32'h300,     0, 1, 1, 32'hC0,        1, 32'h400,     0, 32'hC4,    32'h400,      0, 1));
    tbl.push_back(mk(1, 0, 32'h80,      0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h84,       0, 0));
    tbl.push_back(mk(1, 0, 32'hC0,      0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h400,      1, 0));
    tbl.push_back(mk(1, 0, 32'h600,     1, 1, 0, 32'h10,        1, 32'h700,     0, 32'h14,    32'h700,      0, 1));
    tbl.push_back(mk(1, 0, 32'h600,     1, 1, 0, 32'h20,        1, 32'h800,     0, 32'h24,    32'h800,      0, 1));
    tbl.push_back(mk(1, 0, 32'h600,     1, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h800,      0, 1));
    tbl.push_back(mk(0, 1, 32'h600,     1, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'hC0,      0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'hC4,       0, 0));
    tbl.push_back(mk(1, 0, 32'h1F0,     0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h1F4,      0, 0));
    tbl.push_back(mk(1, 0, 32'h10,      0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,     32'h14,       0, 0));

    rst = 1'b1;
    bus.PC = 0; bus.stall = 0; bus.ex_valid = 0; bus.ex_is_jump = 0; bus.ex_pc = 0;
    bus.ex_taken = 0; bus.ex_target = 0; bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    @(negedge clk);
    next_cycle();

    foreach (tbl[n]) begin
      rst = tbl[n].r;
      bus.PC = tbl[n].pc;             bus.stall = tbl[n].st;
      bus.ex_valid = tbl[n].exv;      bus.ex_is_jump = tbl[n].exj;
      bus.ex_pc = tbl[n].expc;        bus.ex_taken = tbl[n].ext;
      bus.ex_target = tbl[n].extg;    bus.ex_pred_taken = tbl[n].expt;
      bus.ex_pred_target = tbl[n].exptg;
      #1;
      if (tbl[n].chk) begin
        chk($sformatf("vec%0d.npc", n),        bus.NPC,        tbl[n].npc);
        chk($sformatf("vec%0d.pred_taken", n), 32'(bus.pred_taken), 32'(tbl[n].pt));
        chk($sformatf("vec%0d.flush", n),      32'(bus.flush),      32'(tbl[n].fl));
      end
      next_cycle();
    end

    rst = 1'b1;
    bus.ex_valid = 0; bus.stall = 0;
    next_cycle();
    for (int c = 0; c < 600; c++) begin
      rst                = ($urandom_range(0, 99) == 0);
      bus.PC             = rand_pc();
      bus.stall          = ($urandom_range(0, 9) < 3);
      bus.ex_valid       = ($urandom_range(0, 9) < 4);
      bus.ex_is_jump     = ($urandom_range(0, 3) == 0);
      bus.ex_pc          = rand_pc();
      bus.ex_taken       = bus.ex_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      bus.ex_target      = rand_pc();
      bus.ex_pred_taken  = 1'($urandom_range(0, 1));
      bus.ex_pred_target = ($urandom_range(0, 1) == 1) ? bus.ex_target : rand_pc();
      #1;
      if (!rst) begin
        model_eval(e_npc, e_pt, e_ptg, e_fl);
        chk($sformatf("rnd%0d.npc", c),         bus.NPC,              e_npc);
        chk($sformatf("rnd%0d.pred_taken", c),  32'(bus.pred_taken),  32'(e_pt));
        chk($sformatf("rnd%0d.pred_target", c), bus.pred_target,      e_ptg);
        chk($sformatf("rnd%0d.flush", c),       32'(bus.flush),       32'(e_fl));
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/npc_bpu.md
Name: npc_bpu

Overview:
- Next-PC generator feeding the PC register of the RV32I pipeline; produces NPC every cycle from the current PC.
- Predicts branches and jumps with a direct-mapped BTB holding 2-bit saturating counters.
- Resolves predictions against EX-stage outcomes; raises flush and a corrected NPC on mispredict.
- Holds a pending redirect across stall cycles so no correction is lost while the PC register is frozen.

Parameters:
- ENTRIES, 16, number of BTB entries (power of two).
- IDX_W, 4, log2(ENTRIES); index is PC[IDX_W+1:2]; tag is PC[31:IDX_W+2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- PC  in  32  current fetch PC (output of PC register).
- stall  in  1  same stall that freezes the PC register.
- ex_valid  in  1  one-cycle pulse per resolved control-transfer instruction in EX.
- ex_is_jump  in  1  1 = JAL/JALR, 0 = conditional branch (meaningful with ex_valid).
- ex_pc  in  32  PC of the resolving instruction.
- ex_taken  in  1  actual direction (forced 1 for jumps).
- ex_target  in  32  actual target address.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_pred_target  in  32  predicted target carried down the pipe.
- NPC  out  32  next PC to the PC register.
- pred_taken  out  1  prediction for the current PC; carried down the pipe.
- pred_target  out  32  predicted target for the current PC; carried down the pipe.
- flush  out  1  squash IF/ID and ID/EX; asserted on mispredict or pending redirect.

Behaviour:
- BTB state per entry: valid, tag, target[31:0], ctr[1:0], is_jump. Reset clears all valid bits, sets all ctr to 2'b01, sets is_jump to 0, and clears pend. Synchronous only.
- Lookup (combinational): hit = valid[idx] && tag match. pred_taken = hit && (is_jump[idx] || ctr[idx][1]). pred_target = hit ? target[idx] : PC+4.
- Mispredict (combinational): mis = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
- Correct address: corr = ex_taken ? ex_target : ex_pc+4. All adds are 32-bit wrap-around; 32'hFFFF_FFFC+4 = 0.
- Pending redirect: registers pend and pend_addr.
  - If mis && stall: pend <= 1, pend_addr <= corr.
  - pend clears on the first cycle with !stall.
  - If mis occurs while pend=1: pend_addr <= corr. The newest EX resolution wins; the older redirect was on a squashed path.
- NPC priority: mis ? corr : pend ? pend_addr : pred_taken ? pred_target : PC+4.
- flush = mis || pend.
- BTB update at the clock edge when ex_valid, independent of stall. Lookup in the same cycle sees pre-update contents.
  - Hit at ex_pc, branch: ctr saturating +1 if taken, -1 if not taken (00 and 11 saturate). Target overwritten if taken.
  - Miss, taken: allocate (overwrite any valid entry at the index); valid=1, tag, target=ex_target, is_jump=ex_is_jump, ctr=2'b10 (2'b11 for jumps).
  - Miss, not taken: no allocation.
- Reset asserted mid-operation discards pend and all BTB state. After reset NPC = PC+4 until the first allocation.
- Latency: prediction is zero cycles (same cycle as PC). Redirect takes effect on the PC at the first non-stalled edge after mis.

Test Plan:
- Reset, PC=0x0000_0000 -> NPC=0x0000_0004, pred_taken=0, flush=0. Repeat at PC=0xFFFF_FFFC -> NPC=0x0000_0000.
- ex_valid taken branch ex_pc=0x100, ex_target=0x40, pred_taken=0 -> same cycle flush=1, NPC=0x40. Next, PC=0x100 -> pred_taken=1, NPC=0x40 (ctr=10).
- Same branch resolved not-taken twice with prediction 1 -> flush each time, NPC=0x104. ctr goes 10->01->00, then PC=0x100 gives NPC=0x104.
- Mispredict (corr=0x200) with stall=1 for 3 cycles -> flush=1 and NPC=0x200 every stalled cycle. First !stall cycle: PC loads 0x200, pend clears next cycle.
- JAL at 0x080 to 0x300, then JALR at 0x0C0 aliasing the same index with a different tag -> entry replaced. PC=0x080 now misses: NPC=0x084.
- rst asserted while pend=1 -> next cycle pend=0, flush=0, and every previously hit PC returns NPC=PC+4.
